mod_updown_counter: RTL and testbench

Parametrised successor to the team's 4-bit enabled counter. Adds generic width, programmable terminal value, up/down direction, synchronous load and clear, wrap or saturate mode, and an enable prescaler. It provides a combinational carry for cascading and a sticky boundary flag. Used as the general timing/event counter in timer and clock-divider paths.

---
 rtl/mod_updown_counter.sv | 76 +++++++
 tb/tb_mod_updown_counter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
// General-purpose up/down event counter for timer and clock-divider paths.
// It has a programmable terminal value, wrap/saturate modes, an enable prescaler and a cascade carry.
module mod_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 15,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] count,
  output logic             carry_out,
  output logic             boundary_flag
);

  localparam int              PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  localparam logic [PW-1:0]   PLAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    pre;
  logic             tick, step, at_max, at_min;
  logic [WIDTH-1:0] lv_clamp, cnt_up, cnt_dn;

  assign tick   = enable & (pre == PLAST);
  assign step   = tick & ~clear & ~load;
  assign at_max = (count == MAXV);
  assign at_min = (count == '0);

  assign carry_out = step & (up_down ? at_max : at_min);

  assign lv_clamp = (load_value > MAXV) ? MAXV : load_value;

  // Boundary cases are handled explicitly, so a full-range MAX_VAL never relies on WIDTH-bit overflow.
  assign cnt_up = at_max ? ((SATURATE != 0) ? MAXV : '0) : count + WIDTH'(1);
  assign cnt_dn = at_min ? ((SATURATE != 0) ? '0 : MAXV) : count - WIDTH'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre <= '0;
    end else if (clear || load) begin
      pre <= '0;
    end else if (enable) begin
      pre <= tick ? '0 : pre + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= lv_clamp;
    end else if (step) begin
      count <= up_down ? cnt_up : cnt_dn;
    end
  end

  // When a boundary event and flag_clr land on the same edge, the set takes priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      boundary_flag <= 1'b0;
    end else if (carry_out) begin
      boundary_flag <= 1'b1;
    end else if (flag_clr) begin
      boundary_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter. Five parameterisations share one stimulus stream and are
// compared against an arithmetic reference model, plus fixed vectors for the corner cases.
module tb_mod_updown_counter;

  logic       clk;
  logic       reset, enable, up_down, clear, load, flag_clr;
  logic [3:0] lv;
  wire  [3:0] cnt [5];
  wire  [4:0] co, fl;
  logic [4:0] last_co;

  int nchk, nerr;

  // Per-instance parameters: A, B, C, D, E
  int mx  [5] = '{15, 9, 9, 9, 7};
  int sat [5] = '{0, 1, 0, 0, 1};
  int ps  [5] = '{1, 1, 1, 3, 2};
  int msk [5] = '{15, 15, 15, 15, 7};

  int m_cnt [5];
  int m_pre [5];
  int m_flg [5];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(0), .PRESCALE(1)) u_a (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear), .load(load),
    .load_value(lv), .flag_clr(flag_clr), .count(cnt[0]), .carry_out(co[0]), .boundary_flag(fl[0]));
  mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1), .PRESCALE(1)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear), .load(load),
    .load_value(lv), .flag_clr(flag_clr), .count(cnt[1]), .carry_out(co[1]), .boundary_flag(fl[1]));
  mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(1)) u_c (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear), .load(load),
    .load_value(lv), .flag_clr(flag_clr), .count(cnt[2]), .carry_out(co[2]), .boundary_flag(fl[2]));
  mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(3)) u_d (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear), .load(load),
    .load_value(lv), .flag_clr(flag_clr), .count(cnt[3]), .carry_out(co[3]), .boundary_flag(fl[3]));
  mod_updown_counter #(.WIDTH(3), .MAX_VAL(7), .SATURATE(1), .PRESCALE(2)) u_e (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear), .load(load),
    .load_value(lv[2:0]), .flag_clr(flag_clr), .count(cnt[4][2:0]), .carry_out(co[4]), .boundary_flag(fl[4]));
  assign cnt[4][3] = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic bit m_tick(int i);
    return enable && (m_pre[i] == ps[i] - 1);
  endfunction

  function automatic bit m_carry(int i);
    bit stp;
    stp = m_tick(i) && !clear && !load;
    return stp && (up_down ? (m_cnt[i] == mx[i]) : (m_cnt[i] == 0));
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 5; i++) begin
      m_cnt[i] = 0; m_pre[i] = 0; m_flg[i] = 0;
    end
  endfunction

  // Reference: step arithmetic by modulo (wrap) or min/max (saturate), prescaler as a modulo count.
  function automatic void m_edge();
    for (int i = 0; i < 5; i++) begin
      bit c, t;
      int v;
      c = m_carry(i);
      t = m_tick(i);
      if (clear) begin
        m_cnt[i] = 0; m_pre[i] = 0;
      end else if (load) begin
        v = int'(lv) & msk[i];
        m_cnt[i] = (v > mx[i]) ? mx[i] : v;
        m_pre[i] = 0;
      end else begin
        if (enable) m_pre[i] = (m_pre[i] + 1) % ps[i];
        if (t) begin
          if (up_down)
            m_cnt[i] = sat[i] ? ((m_cnt[i] + 1 > mx[i]) ? mx[i] : m_cnt[i] + 1)
                              : (m_cnt[i] + 1) % (mx[i] + 1);
          else
            m_cnt[i] = sat[i] ? ((m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1)
                              : (m_cnt[i] + mx[i]) % (mx[i] + 1);
        end
      end
      if (c) m_flg[i] = 1;
      else if (flag_clr) m_flg[i] = 0;
    end
  endfunction

  task automatic do_cycle(input logic en, ud, clr, ld, input logic [3:0] v, input logic fc);
    enable = en; up_down = ud; clear = clr; load = ld; lv = v; flag_clr = fc;
    #1;
    for (int i = 0; i < 5; i++) begin
      last_co[i] = co[i];
      chk($sformatf("carry[%0d]", i), 32'(co[i]), 32'(m_carry(i)));
    end
    m_edge();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("count[%0d]", i), 32'(cnt[i]), m_cnt[i]);
      chk($sformatf("flag[%0d]", i), 32'(fl[i]), m_flg[i]);
    end
  endtask

  typedef struct {
    logic en, ud, clr, ld;
    logic [3:0] lv;
    logic fc;
    int b_cnt, c_cnt;
    logic b_co, c_co;
  } vec_t;

  vec_t tbl [10];
  int   es  [8] = '{1, 1, 0, 0, 1, 1, 1, 1};
  int   ed  [8] = '{0, 0, 0, 0, 1, 1, 1, 2};

  initial begin
    nchk = 0; nerr = 0;
    // B: MAX 9 saturate, C: MAX 9 wrap
    tbl[0] = '{1, 0, 0, 1, 4'd2,  0, 2, 2, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 4'd0,  0, 1, 1, 0, 0};
    tbl[2] = '{1, 0, 0, 0, 4'd0,  0, 0, 0, 0, 0};
    tbl[3] = '{1, 0, 0, 0, 4'd0,  0, 0, 9, 1, 1};
    tbl[4] = '{1, 0, 0, 0, 4'd0,  0, 0, 8, 1, 0};
    tbl[5] = '{1, 1, 1, 1, 4'd5,  0, 0, 0, 0, 0};
    tbl[6] = '{0, 1, 0, 1, 4'd12, 0, 9, 9, 0, 0};
    tbl[7] = '{1, 1, 0, 1, 4'd4,  0, 4, 4, 0, 0};
    tbl[8] = '{0, 1, 0, 0, 4'd0,  0, 4, 4, 0, 0};
    tbl[9] = '{1, 1, 0, 0, 4'd0,  0, 5, 5, 0, 0};

    reset = 1'b1; enable = 0; up_down = 0; clear = 0; load = 0; lv = '0; flag_clr = 0;
    last_co = '0;
    #1 reset = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rst_count[%0d]", i), 32'(cnt[i]), 0);
      chk($sformatf("rst_flag[%0d]", i), 32'(fl[i]), 0);
    end
    @(negedge clk);
    reset = 1'b1;
    m_reset();

    // Free-running up count on A: wraps after 15, flag rises with the wrap
    for (int k = 1; k <= 20; k++) begin
      do_cycle(1, 1, 0, 0, 4'd0, 0);
      chk("basic_carry", 32'(last_co[0]), 32'(((k - 1) % 16) == 15));
      chk("basic_count", 32'(cnt[0]), k % 16);
      chk("basic_flag", 32'(fl[0]), 32'(k >= 16));
    end

    for (int r = 0; r < 10; r++) begin
      do_cycle(tbl[r].en, tbl[r].ud, tbl[r].clr, tbl[r].ld, tbl[r].lv, tbl[r].fc);
      chk($sformatf("tbl%0d_b_carry", r), 32'(last_co[1]), 32'(tbl[r].b_co));
      chk($sformatf("tbl%0d_c_carry", r), 32'(last_co[2]), 32'(tbl[r].c_co));
      chk($sformatf("tbl%0d_b_count", r), 32'(cnt[1]), tbl[r].b_cnt);
      chk($sformatf("tbl%0d_c_count", r), 32'(cnt[2]), tbl[r].c_cnt);
    end

    // Prescale-by-3 on D with enable gaps
    do_cycle(0, 1, 1, 0, 4'd0, 0);
    for (int k = 0; k < 8; k++) begin
      do_cycle(es[k] != 0, 1, 0, 0, 4'd0, 0);
      chk($sformatf("presc%0d_count", k), 32'(cnt[3]), ed[k]);
    end

    // D at count 7, prescaler phase 1, then an async reset between edges
    do_cycle(0, 1, 0, 1, 4'd7, 0);
    do_cycle(1, 1, 0, 0, 4'd0, 0);
    chk("pre_rst_d_count", 32'(cnt[3]), 7);
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("async_count[%0d]", i), 32'(cnt[i]), 0);
      chk($sformatf("async_flag[%0d]", i), 32'(fl[i]), 0);
    end
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_cycle(1, 1, 0, 0, 4'd0, 0);
      chk($sformatf("post_rst%0d_d_count", k), 32'(cnt[3]), (k == 2) ? 1 : 0);
    end

    // Flag set/clear race on A
    do_cycle(0, 1, 0, 1, 4'd15, 0);
    do_cycle(1, 1, 0, 0, 4'd0, 1);
    chk("race_carry", 32'(last_co[0]), 1);
    chk("race_count", 32'(cnt[0]), 0);
    chk("race_flag", 32'(fl[0]), 1);
    do_cycle(0, 1, 0, 0, 4'd0, 1);
    chk("flagclr_flag", 32'(fl[0]), 0);

    for (int k = 0; k < 600; k++) begin
      do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
               $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
               4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
